// File: rtl/booth_mult_ctrl.sv
// Sequencer for the 16-cycle radix-2 Booth multiplier: operand handshake, start pulse, timeout, product handshake.
// Optional ZERO_BYPASS_EN: zero operands skip the multiplier and return 0 one cycle after acceptance.
module booth_mult_ctrl #(
    parameter int DW          = 16,
    parameter int TIMEOUT_CYC = 20
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_mc,
    input  logic [DW-1:0]   in_mp,
    output logic            mult_start,
    output logic [DW-1:0]   mult_mc,
    output logic [DW-1:0]   mult_mp,
    input  logic            mult_ready,
    input  logic [2*DW-1:0] mult_prod,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] out_prod,
    output logic            err
);

    localparam int CW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_RUN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [DW-1:0]   r_mc;
    logic [DW-1:0]   r_mp;
    logic [2*DW-1:0] r_prod;
    logic            r_err;
    logic [CW-1:0]   r_tcnt;
    logic            w_zero;
    logic            w_accept;
    logic            w_tout;

`ifdef ZERO_BYPASS_EN
    // Decided on the registered pair, so the bypass result lands one cycle after accept
    assign w_zero = (r_mc == '0) || (r_mp == '0);
`else
    assign w_zero = 1'b0;
`endif

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_tout   = (r_tcnt >= TMAX);

    assign mult_mc  = r_mc;
    assign mult_mp  = r_mp;
    assign out_prod = r_prod;
    assign err      = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        in_ready   = 1'b0;
        mult_start = 1'b0;
        out_valid  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_LOAD;
            end
            S_LOAD: begin
                if (w_zero) begin
                    w_next = S_DONE;
                end else begin
                    mult_start = 1'b1;
                    w_next     = S_ARM;
                end
            end
            // Multiplier count is stale until the start edge has passed
            S_ARM: w_next = S_RUN;
            S_RUN: begin
                if (mult_ready || w_tout) w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mc   <= '0;
            r_mp   <= '0;
            r_prod <= '0;
            r_err  <= 1'b0;
            r_tcnt <= '0;
        end else begin
            if (w_accept) begin
                r_mc  <= in_mc;
                r_mp  <= in_mp;
                r_err <= 1'b0;
            end
            if (r_state == S_LOAD && w_zero) begin
                r_prod <= '0;
            end
            if (r_state == S_ARM) begin
                r_tcnt <= '0;
            end else if (r_state == S_RUN && !w_tout) begin
                r_tcnt <= r_tcnt + CW'(1);
            end
            // Ready beats timeout when both occur in the same cycle
            if (r_state == S_RUN) begin
                if (mult_ready) begin
                    r_prod <= mult_prod;
                end else if (w_tout) begin
                    r_err  <= 1'b1;
                    r_prod <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Scoreboard bench for booth_mult_ctrl with a behavioural 16-iteration multiplier.
// Honours ZERO_BYPASS_EN for the zero-operand expectations.
module tb_booth_mult_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_mc = '0;
    logic [15:0] in_mp = '0;
    logic        mult_start;
    logic [15:0] mult_mc;
    logic [15:0] mult_mp;
    logic        mult_ready;
    logic [31:0] mult_prod;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_prod;
    logic        err;

    booth_mult_ctrl #(.DW(16), .TIMEOUT_CYC(20)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mc      (in_mc),
        .in_mp      (in_mp),
        .mult_start (mult_start),
        .mult_mc    (mult_mc),
        .mult_mp    (mult_mp),
        .mult_ready (mult_ready),
        .mult_prod  (mult_prod),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_prod   (out_prod),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] prod;
        logic        er;
        int          lat;
        int          st;
        int          acc;
        int          st0;
        int          hold;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   nstart = 0;

`ifdef ZERO_BYPASS_EN
    localparam int ZLAT = 1;
    localparam int ZST  = 0;
`else
    localparam int ZLAT = 18;
    localparam int ZST  = 1;
`endif

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mult_start) nstart <= nstart + 1;
    end

    // Multiplier stand-in: no reset, count starts saturated (stale ready)
    logic [4:0]  m_cnt = 5'd16;
    logic [31:0] m_prod = '0;
    bit          force_nr = 1'b0;

    always @(posedge clk) begin
        if (mult_start) begin
            m_cnt  <= 5'd0;
            m_prod <= {{16{mult_mc[15]}}, mult_mc} * {{16{mult_mp[15]}}, mult_mp};
        end else if (m_cnt < 5'd16) begin
            m_cnt <= m_cnt + 5'd1;
        end
    end

    assign mult_ready = (m_cnt == 5'd16) && !force_nr;
    assign mult_prod  = (m_cnt == 5'd16) ? m_prod : 32'hDEADBEEF;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, ex);
        end
    endtask

    bit          busy = 1'b0;
    int          hold_c = 0;
    logic [31:0] held = '0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy = 1'b0;
            out_ready = 1'b1;
        end else if (out_valid) begin
            if (!busy) begin
                busy = 1'b1;
                held = out_prod;
                if (q.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                    hold_c = 0;
                end else begin
                    e = q.pop_front();
                    chk("out_prod", out_prod, e.prod);
                    chk("err", 32'(err), 32'(e.er));
                    chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                    chk("start_pulses", 32'(nstart - e.st0), 32'(e.st));
                    hold_c = e.hold;
                end
                out_ready = (hold_c == 0);
            end else begin
                chk("prod_hold", out_prod, held);
                chk("in_ready_done", 32'(in_ready), 32'd0);
                if (hold_c > 0) hold_c--;
                out_ready = (hold_c == 0);
            end
        end else if (busy) begin
            busy = 1'b0;
        end
    end

    // Called and returns on a falling edge
    task automatic send(input logic [15:0] mc, input logic [15:0] mp,
                        input logic [31:0] prod, input logic er,
                        input int lat, input int st, input int hd);
        exp_t e;
        int n = 0;
        in_mc    = mc;
        in_mp    = mp;
        in_valid = 1'b1;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_mc    = 16'($urandom);
        in_mp    = 16'($urandom);
        e.prod = prod;
        e.er   = er;
        e.lat  = lat;
        e.st   = st;
        e.acc  = cyc;
        e.st0  = nstart;
        e.hold = hd;
        q.push_back(e);
        chk("mult_mc_reg", 32'(mult_mc), 32'(mc));
        chk("mult_mp_reg", 32'(mult_mp), 32'(mp));
        chk("err_clear", 32'(err), 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || busy) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_mult_start"}, 32'(mult_start), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_mult_mc"}, 32'(mult_mc), 32'd0);
        chk({tag, "_mult_mp"}, 32'(mult_mp), 32'd0);
        chk({tag, "_out_prod"}, out_prod, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #2;
        reset_checks("rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        send(16'd3, 16'd5, 32'h0000000F, 1'b0, 18, 1, 0);
        send(16'hFFF9, 16'd6, 32'hFFFFFFD6, 1'b0, 18, 1, 0);
        send(16'h8000, 16'h8000, 32'h40000000, 1'b0, 18, 1, 0);
        send(16'h7FFF, 16'h8000, 32'hC0008000, 1'b0, 18, 1, 5);
        send(16'hFFFF, 16'hFFFF, 32'h00000001, 1'b0, 18, 1, 0);
        drain();

        send(16'd0, 16'd1234, 32'h00000000, 1'b0, ZLAT, ZST, 0);
        drain();

        force_nr = 1'b1;
        send(16'd3, 16'd5, 32'h00000000, 1'b1, 22, 1, 0);
        drain();
        force_nr = 1'b0;
        send(16'd4, 16'd4, 32'h00000010, 1'b0, 18, 1, 0);
        drain();

        send(16'd100, 16'd100, 32'h00002710, 1'b0, 18, 1, 0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        reset_checks("midrst");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(16'd2, 16'd3, 32'h00000006, 1'b0, 18, 1, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
